// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and scan-code keymap for the PS/2 key tracker.
// The keymap lists the 16 game keys as {ext, code} pairs in key-index order.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVRF  = 8'hFF;

    localparam int         KEYMAP_SIZE = 16;
    // Pause sends E1 followed by 7 more bytes that must be swallowed.
    localparam logic [2:0] SKIP_LEN    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_fsm_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } keymap_entry_t;

    localparam keymap_entry_t KEYMAP [KEYMAP_SIZE] = '{
        '{1'b0, 8'h1D},  // W
        '{1'b0, 8'h1B},  // S
        '{1'b0, 8'h1C},  // A
        '{1'b0, 8'h23},  // D
        '{1'b1, 8'h75},  // Up
        '{1'b1, 8'h72},  // Down
        '{1'b1, 8'h6B},  // Left
        '{1'b1, 8'h74},  // Right
        '{1'b0, 8'h29},  // Space
        '{1'b0, 8'h5A},  // Enter
        '{1'b0, 8'h76},  // Esc
        '{1'b0, 8'h4D},  // P
        '{1'b0, 8'h2D},  // R
        '{1'b0, 8'h21},  // C
        '{1'b0, 8'h79},  // KP+
        '{1'b0, 8'h7B}   // KP-
    };

    function automatic logic is_resync(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_OVR0) || (b == PS2_OVRF);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational lookup of an {ext, code} scan pair into a game-key index.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < KEYMAP_SIZE; i++) begin
            if (KEYMAP[i].ext == ext && KEYMAP[i].code == code) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 make/break/E0/E1 byte sequences into a held-key vector with
// one-cycle press/release pulses for up to 16 game keys.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS        = 16,
    parameter int CLEAR_ON_RESYNC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_state,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_key
);

    ps2_fsm_e            fsm_state, fsm_next;
    logic [2:0]          skip_cnt, skip_next, skip_dec;
    logic                ps2_state_d;
    logic                accept;
    logic                ext_flag;
    logic                map_hit;
    logic [3:0]          map_idx;
    logic [15:0]         map_onehot;
    logic [NUM_KEYS-1:0] key_mask;
    logic                held;
    logic [NUM_KEYS-1:0] keys_next, press_next, release_next;

    assign accept   = ps2_state & ~ps2_state_d;
    assign ext_flag = (fsm_state == ST_EXT) || (fsm_state == ST_EXT_BRK);
    assign skip_dec = skip_cnt - 3'd1;

    ps2_keymap u_keymap (
        .ext  (ext_flag),
        .code (ps2_byte),
        .hit  (map_hit),
        .idx  (map_idx)
    );

    // Indices beyond NUM_KEYS fall off the truncated one-hot and act as unmapped.
    assign map_onehot = 16'd1 << map_idx;
    assign key_mask   = map_hit ? map_onehot[NUM_KEYS-1:0] : '0;
    assign held       = |(keys & key_mask);

    always_comb begin
        fsm_next     = fsm_state;
        skip_next    = skip_cnt;
        keys_next    = keys;
        press_next   = '0;
        release_next = '0;

        if (accept) begin
            if (CLEAR_ON_RESYNC != 0 && is_resync(ps2_byte)) begin
                fsm_next  = ST_IDLE;
                skip_next = '0;
                keys_next = '0;
            end else if (fsm_state == ST_SKIP) begin
                skip_next = skip_dec;
                if (skip_dec == 3'd0) begin
                    fsm_next = ST_IDLE;
                end
            end else if (ps2_byte == PS2_PAUSE) begin
                fsm_next  = ST_SKIP;
                skip_next = SKIP_LEN;
            end else if (ps2_byte == PS2_EXT) begin
                if (fsm_state == ST_IDLE) begin
                    fsm_next = ST_EXT;
                end else if (fsm_state == ST_BRK) begin
                    fsm_next = ST_EXT_BRK;
                end
            end else if (ps2_byte == PS2_BRK) begin
                if (fsm_state == ST_IDLE) begin
                    fsm_next = ST_BRK;
                end else if (fsm_state == ST_EXT) begin
                    fsm_next = ST_EXT_BRK;
                end
            end else begin
                fsm_next = ST_IDLE;
                if (fsm_state == ST_IDLE || fsm_state == ST_EXT) begin
                    // Typematic repeats of a held key produce nothing.
                    if (!held) begin
                        keys_next  = keys | key_mask;
                        press_next = key_mask;
                    end
                end else if (held) begin
                    keys_next    = keys & ~key_mask;
                    release_next = key_mask;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            fsm_state   <= ST_IDLE;
            skip_cnt    <= '0;
            ps2_state_d <= 1'b1;   // a byte already present at reset is never consumed
            keys        <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_key     <= 1'b0;
        end else begin
            fsm_state   <= fsm_next;
            skip_cnt    <= skip_next;
            ps2_state_d <= ps2_state;
            keys        <= keys_next;
            key_press   <= press_next;
            key_release <= release_next;
            any_key     <= |keys_next;
        end
    end

endmodule
